// File: rtl/scan_addr_decoder_pkg.sv
// Shared types and constants for the scan address path.
package scan_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] offset;
    logic [15:0]       x_stride;
    logic [ADDR_W-1:0] y_stride;
    logic [ADDR_W-1:0] x_max;
    logic [ADDR_W-1:0] y_max;
  } scan_cfg_t;

endpackage

// File: rtl/scan_addr_decoder_if.sv
// Address-in / decoded-beat-out handshake bundle of the scan decoder.
interface scan_addr_decoder_if #(
  parameter int CNT_W = 16
);
  import scan_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_x;
  logic [CNT_W-1:0]  out_y;
  logic              out_row_last;
  logic              out_frame_last;
  logic              out_mismatch;

  modport master (
    output in_valid, in_addr, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_row_last, out_frame_last, out_mismatch
  );

  modport slave (
    input  in_valid, in_addr, out_ready,
    output in_ready, out_valid, out_x, out_y, out_row_last, out_frame_last, out_mismatch
  );

endinterface

// File: rtl/scan_addr_decoder_pos_counter.sv
// x/y scan position plus running address accumulator; advances one beat per
// i_advance and wraps to (0,0) after the last beat of a frame.
module scan_pos_counter
  import scan_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  input  scan_cfg_t         i_cfg,
  output logic [CNT_W-1:0]  o_x,
  output logic [CNT_W-1:0]  o_y,
  output logic [ADDR_W-1:0] o_acc,
  output logic              o_row_last,
  output logic              o_frame_last
);

  logic [CNT_W-1:0]  r_x;
  logic [CNT_W-1:0]  r_y;
  logic [ADDR_W-1:0] r_acc;
  logic              w_rowLast;
  logic              w_colLast;

  // Compare zero-extended indices against the full-width limits
  assign w_rowLast = (ADDR_W'(r_x) == i_cfg.x_max);
  assign w_colLast = (ADDR_W'(r_y) == i_cfg.y_max);

  // Step within a row, jump to the next row, or wrap at the end of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
    end else if (i_advance) begin
      if (!w_rowLast) begin
        r_x   <= r_x + CNT_W'(1);
        r_acc <= r_acc + {16'b0, i_cfg.x_stride};
      end else if (!w_colLast) begin
        r_x   <= '0;
        r_y   <= r_y + CNT_W'(1);
        r_acc <= r_acc + i_cfg.y_stride;
      end else begin
        r_x   <= '0;
        r_y   <= '0;
        r_acc <= '0;
      end
    end
  end

  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_acc        = r_acc;
  assign o_row_last   = w_rowLast;
  assign o_frame_last = w_rowLast && w_colLast;

endmodule

// File: rtl/scan_addr_decoder.sv
// Rebuilds (x, y) from an incoming scan address stream, flags row/frame ends
// and counts addresses that differ from the expected sequence.
module scan_addr_decoder
  import scan_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] offset,
  input  logic [15:0]       x_stride,
  input  logic [ADDR_W-1:0] y_stride,
  input  logic [ADDR_W-1:0] x_max,
  input  logic [ADDR_W-1:0] y_max,
  scan_addr_decoder_if.slave bus,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy
);

  scan_state_t       r_state;
  scan_state_t       w_nextState;
  scan_cfg_t         r_cfg;
  logic              w_busy;
  logic              w_inReady;
  logic              w_accept;
  logic              w_mismatch;
  logic [CNT_W-1:0]  w_posX;
  logic [CNT_W-1:0]  w_posY;
  logic [ADDR_W-1:0] w_acc;
  logic [ADDR_W-1:0] w_expected;
  logic              w_rowLast;
  logic              w_frameLast;
  logic              r_outValid;
  logic [CNT_W-1:0]  r_outX;
  logic [CNT_W-1:0]  r_outY;
  logic              r_outRowLast;
  logic              r_outFrameLast;
  logic              r_outMismatch;
  logic [ERR_W-1:0]  r_errCount;

  assign w_accept   = bus.in_valid && w_inReady;
  assign w_expected = w_acc + r_cfg.offset;
  assign w_mismatch = (bus.in_addr != w_expected);

  scan_pos_counter #(
    .CNT_W (CNT_W)
  ) u_pos (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (cfg_load),
    .i_advance    (w_accept),
    .i_cfg        (r_cfg),
    .o_x          (w_posX),
    .o_y          (w_posY),
    .o_acc        (w_acc),
    .o_row_last   (w_rowLast),
    .o_frame_last (w_frameLast)
  );

  // Latch the scan configuration whenever a new scan is started
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg <= '0;
    end else if (cfg_load) begin
      r_cfg.offset   <= offset;
      r_cfg.x_stride <= x_stride;
      r_cfg.y_stride <= y_stride;
      r_cfg.x_max    <= x_max;
      r_cfg.y_max    <= y_max;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: restart on cfg_load, fall back to IDLE after the frame's last beat
  always_comb begin
    w_nextState = r_state;
    if (cfg_load) begin
      w_nextState = RUN;
    end else if ((r_state == RUN) && w_accept && w_frameLast) begin
      w_nextState = IDLE;
    end
  end

  // FSM outputs: accept only while running, the output slot is free, and no restart is in progress
  always_comb begin
    w_busy    = 1'b0;
    w_inReady = 1'b0;
    if (r_state == RUN) begin
      w_busy    = 1'b1;
      w_inReady = (!r_outValid || bus.out_ready) && !cfg_load;
    end
  end

  // One-entry output register; holds its beat until downstream takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid     <= 1'b0;
      r_outX         <= '0;
      r_outY         <= '0;
      r_outRowLast   <= 1'b0;
      r_outFrameLast <= 1'b0;
      r_outMismatch  <= 1'b0;
    end else if (w_accept) begin
      r_outValid     <= 1'b1;
      r_outX         <= w_posX;
      r_outY         <= w_posY;
      r_outRowLast   <= w_rowLast;
      r_outFrameLast <= w_frameLast;
      r_outMismatch  <= w_mismatch;
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Saturating mismatch counter, cleared when a new scan starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCount <= '0;
    end else if (cfg_load) begin
      r_errCount <= '0;
    end else if (w_accept && w_mismatch && (r_errCount != '1)) begin
      r_errCount <= r_errCount + ERR_W'(1);
    end
  end

  assign bus.in_ready       = w_inReady;
  assign bus.out_valid      = r_outValid;
  assign bus.out_x          = r_outX;
  assign bus.out_y          = r_outY;
  assign bus.out_row_last   = r_outRowLast;
  assign bus.out_frame_last = r_outFrameLast;
  assign bus.out_mismatch   = r_outMismatch;
  assign err_count          = r_errCount;
  assign busy               = w_busy;

endmodule

// File: tb/tb_scan_addr_decoder.sv
// Self-checking bench for scan_addr_decoder: directed scenarios plus random
// frames, all checked every cycle against a position/address model.
module tb_scan_addr_decoder;
  import scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [31:0] offset = '0;
  logic [15:0] x_stride = '0;
  logic [31:0] y_stride = '0;
  logic [31:0] x_max = '0;
  logic [31:0] y_max = '0;
  logic [15:0] errCount;
  logic [1:0]  errCount2;
  logic        busy;
  logic        busy2;

  int totalCount = 0;
  int badCount = 0;

  scan_addr_decoder_if #(.CNT_W(16)) ifc ();
  scan_addr_decoder_if #(.CNT_W(16)) ifc2 ();

  assign ifc2.in_valid  = ifc.in_valid;
  assign ifc2.in_addr   = ifc.in_addr;
  assign ifc2.out_ready = ifc.out_ready;

  scan_addr_decoder #(.CNT_W(16), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .offset(offset), .x_stride(x_stride),
    .y_stride(y_stride), .x_max(x_max), .y_max(y_max), .bus(ifc.slave),
    .err_count(errCount), .busy(busy)
  );

  scan_addr_decoder #(.CNT_W(16), .ERR_W(2)) dutSat (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .offset(offset), .x_stride(x_stride),
    .y_stride(y_stride), .x_max(x_max), .y_max(y_max), .bus(ifc2.slave),
    .err_count(errCount2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Comparison helper: counts every check and reports failures
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address the generator emits for position (x, y)
  function automatic logic [31:0] addrOf(input logic [31:0] off, input logic [31:0] xs,
                                         input logic [31:0] ys, input logic [31:0] xm,
                                         input longint x, input longint y);
    return off + 32'(y) * (xm * xs + ys) + 32'(x) * xs;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Reference model state (beat index within frame, not x/y registers)
  bit          mBusy = 0;
  bit          mOV = 0;
  longint      mK = 0;
  logic [31:0] mOff = '0, mXs = '0, mYs = '0, mXm = '0, mYm = '0;
  longint      mX = 0, mY = 0;
  bit          mRL = 0, mFL = 0, mMM = 0;
  int          mErr = 0;

  typedef struct {
    int x;
    int y;
    bit rl;
    bit fl;
    bit mm;
  } beat_t;
  beat_t cap[$];

  // Per-cycle compare against the model, then advance the model over the coming edge
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_out_valid", ifc.out_valid, 0);
      checkOutput("rst_in_ready", ifc.in_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", errCount, 0);
      checkOutput("rst_fields", {ifc.out_x, ifc.out_y, ifc.out_row_last, ifc.out_frame_last, ifc.out_mismatch}, 0);
      mBusy = 0; mOV = 0; mK = 0; mErr = 0;
      mOff = '0; mXs = '0; mYs = '0; mXm = '0; mYm = '0;
      mX = 0; mY = 0; mRL = 0; mFL = 0; mMM = 0;
    end else begin
      bit expReady;
      bit acc;
      longint rowLen, total;
      logic [31:0] expA;
      expReady = mBusy && (!mOV || ifc.out_ready) && !cfg_load;
      checkOutput("in_ready", ifc.in_ready, expReady);
      checkOutput("out_valid", ifc.out_valid, mOV);
      checkOutput("busy", busy, mBusy);
      checkOutput("err_count", errCount, sat(mErr, 65535));
      checkOutput("err_count_sat", errCount2, sat(mErr, 3));
      checkOutput("in_ready_sat", ifc2.in_ready, expReady);
      if (mOV) begin
        checkOutput("out_x", ifc.out_x, mX);
        checkOutput("out_y", ifc.out_y, mY);
        checkOutput("out_flags", {ifc.out_row_last, ifc.out_frame_last, ifc.out_mismatch}, {mRL, mFL, mMM});
      end
      if (ifc.out_valid && ifc.out_ready)
        cap.push_back('{int'(ifc.out_x), int'(ifc.out_y), ifc.out_row_last, ifc.out_frame_last, ifc.out_mismatch});
      acc = ifc.in_valid && expReady;
      if (cfg_load) begin
        mBusy = 1; mK = 0; mErr = 0;
        mOff = offset; mXs = {16'b0, x_stride}; mYs = y_stride; mXm = x_max; mYm = y_max;
      end
      if (acc) begin
        rowLen = longint'(mXm) + 1;
        total  = rowLen * (longint'(mYm) + 1);
        mX  = mK % rowLen;
        mY  = mK / rowLen;
        expA = addrOf(mOff, mXs, mYs, mXm, mX, mY);
        mRL = (mX == longint'(mXm));
        mFL = mRL && (mY == longint'(mYm));
        mMM = (ifc.in_addr != expA);
        mOV = 1;
        if (mMM) mErr++;
        mK++;
        if (mK == total) begin
          mK = 0;
          mBusy = 0;
        end
      end else if (ifc.out_ready) begin
        mOV = 0;
      end
    end
  end

  // out_ready pattern generator: 0 always ready, 1 toggling 1,0,0,1, 2 stalled, 3 random
  int readyMode = 0;
  int cycleIdx = 0;
  bit pat[4];

  task automatic tick();
    @(posedge clk);
    #1;
    cycleIdx++;
    case (readyMode)
      0: ifc.out_ready = 1'b1;
      1: ifc.out_ready = pat[cycleIdx % 4];
      2: ifc.out_ready = 1'b0;
      default: ifc.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic loadCfg(input logic [31:0] off, input logic [15:0] xs, input logic [31:0] ys,
                         input logic [31:0] xm, input logic [31:0] ym);
    offset = off; x_stride = xs; y_stride = ys; x_max = xm; y_max = ym;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Present one address and wait (bounded) until the decoder takes it
  task automatic applyStimulus(input logic [31:0] addr, input int gap);
    bit hs;
    bit done;
    repeat (gap) tick();
    ifc.in_valid = 1'b1;
    ifc.in_addr  = addr;
    done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      hs = ifc.in_ready;
      tick();
      if (hs) done = 1;
    end
    ifc.in_valid = 1'b0;
    checkOutput("handshake", done, 1);
  endtask

  task automatic drain(input int n);
    readyMode = 0;
    repeat (n) tick();
  endtask

  logic [31:0] nomStream[8];
  int          expX[8];

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rOff, rYs, rXm, rYm, a;
    logic [15:0] rXs;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    nomStream = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h14C, 32'h150, 32'h154, 32'h158};
    expX = '{0, 1, 2, 3, 0, 1, 2, 3};
    ifc.in_valid = 1'b0;
    ifc.in_addr = '0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("idle_in_ready", ifc.in_ready, 0);
    checkOutput("idle_busy", busy, 0);

    // Nominal frame
    loadCfg(32'h100, 16'd4, 32'h40, 32'd3, 32'd1);
    cap.delete();
    for (int i = 0; i < 8; i++) applyStimulus(nomStream[i], 0);
    checkOutput("nom_busy_after", busy, 0);
    drain(3);
    checkOutput("nom_count", cap.size(), 8);
    if (cap.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput("nom_x", cap[i].x, expX[i]);
        checkOutput("nom_y", cap[i].y, (i < 4) ? 0 : 1);
        checkOutput("nom_row_last", cap[i].rl, (i == 3 || i == 7));
        checkOutput("nom_frame_last", cap[i].fl, (i == 7));
      end
    end
    checkOutput("nom_err", errCount, 0);

    // Back-pressure
    loadCfg(32'h100, 16'd4, 32'h40, 32'd3, 32'd1);
    cap.delete();
    readyMode = 1;
    for (int i = 0; i < 8; i++) applyStimulus(nomStream[i], 0);
    drain(4);
    checkOutput("bp_count", cap.size(), 8);
    if (cap.size() == 8)
      for (int i = 0; i < 8; i++) checkOutput("bp_x", cap[i].x, expX[i]);

    // Mismatch on beat 3
    loadCfg(32'h100, 16'd4, 32'h40, 32'd3, 32'd1);
    cap.delete();
    for (int i = 0; i < 8; i++) applyStimulus((i == 2) ? 32'h109 : nomStream[i], 0);
    drain(3);
    checkOutput("mm_err", errCount, 1);
    if (cap.size() == 8) begin
      checkOutput("mm_beat3", cap[2].mm, 1);
      checkOutput("mm_beat4_x", cap[3].x, 3);
      checkOutput("mm_beat4_mm", cap[3].mm, 0);
      checkOutput("mm_beat8_mm", cap[7].mm, 0);
    end else checkOutput("mm_count", cap.size(), 8);

    // Degenerate single-beat frame
    loadCfg(32'h100, 16'd4, 32'h40, 32'd0, 32'd0);
    cap.delete();
    applyStimulus(32'h100, 0);
    checkOutput("deg_busy", busy, 0);
    checkOutput("deg_in_ready", ifc.in_ready, 0);
    drain(2);
    checkOutput("deg_count", cap.size(), 1);
    if (cap.size() == 1) checkOutput("deg_flags", {cap[0].rl, cap[0].fl, cap[0].mm}, 3'b110);

    // Restart while a beat is held
    loadCfg(32'h100, 16'd4, 32'h40, 32'd3, 32'd1);
    cap.delete();
    applyStimulus(32'h100, 0);
    applyStimulus(32'h999, 0);
    readyMode = 2;
    ifc.out_ready = 1'b0;
    loadCfg(32'h100, 16'd4, 32'h40, 32'd3, 32'd1);
    checkOutput("rs_err_cleared", errCount, 0);
    readyMode = 0;
    ifc.out_ready = 1'b1;
    applyStimulus(32'h100, 0);
    drain(2);
    checkOutput("rs_count", cap.size(), 3);
    if (cap.size() == 3) begin
      checkOutput("rs_held_mm", cap[1].mm, 1);
      checkOutput("rs_first", {cap[2].x, cap[2].y, 29'(cap[2].mm)}, 0);
    end

    // Reset mid-frame
    loadCfg(32'h100, 16'd4, 32'h40, 32'd3, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(nomStream[i], 0);
    ifc.in_valid = 1'b1;
    ifc.in_addr  = 32'h14C;
    rst = 1'b1;
    #1;
    checkOutput("rst_now_valid", ifc.out_valid, 0);
    checkOutput("rst_now_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_stay_busy", busy, 0);
    checkOutput("rst_stay_ready", ifc.in_ready, 0);
    ifc.in_valid = 1'b0;

    // Saturation with a 2-bit counter
    loadCfg(32'h100, 16'd4, 32'h40, 32'd7, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(32'hDEAD0000 + i, 0);
    drain(2);
    checkOutput("sat_err2", errCount2, 3);
    checkOutput("sat_err16", errCount, 5);

    // Random frames
    for (int t = 0; t < 8; t++) begin
      rOff = $urandom;
      rXs  = 16'($urandom);
      rYs  = $urandom;
      rXm  = $urandom_range(0, 4);
      rYm  = $urandom_range(0, 3);
      loadCfg(rOff, rXs, rYs, rXm, rYm);
      readyMode = 3;
      for (int y = 0; y <= int'(rYm); y++) begin
        for (int x = 0; x <= int'(rXm); x++) begin
          a = addrOf(rOff, {16'b0, rXs}, rYs, rXm, x, y);
          if ($urandom_range(0, 4) == 0) a = a ^ 32'h10;
          applyStimulus(a, $urandom_range(0, 2));
        end
      end
      drain(3);
      checkOutput("rand_busy_end", busy, 0);
    end

    drain(2);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/scan_addr_decoder.md
# scan_addr_decoder

Receiving end of the 2D strided scan address stream. Consumes one 32-bit address per handshake and rebuilds the (x, y) scan position that produced it from the same scan configuration. Flags row and frame boundaries, and checks every address against the expected scan sequence. Sits on the memory side of the scan address generator and feeds position and boundary information to the downstream data consumer.

## Interface
Parameters:
- CNT_W, 16: width of x/y index outputs; x_max and y_max must fit in CNT_W bits.
- ERR_W, 16: width of the mismatch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_load  in  1  pulse: latch config and (re)start the scan at (0,0).
- offset  in  32  base address.
- x_stride  in  16  step within a row; zero-extended.
- y_stride  in  32  step from the last x of a row to the first x of the next row.
- x_max  in  32  last x index (row has x_max+1 beats).
- y_max  in  32  last y index (frame has y_max+1 rows).
- in_valid  in  1  address beat valid.
- in_ready  out  1  decoder can accept a beat.
- in_addr  in  32  address from generator.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  downstream accepts.
- out_x  out  CNT_W  x index of beat.
- out_y  out  CNT_W  y index of beat.
- out_row_last  out  1  beat is x == x_max.
- out_frame_last  out  1  beat is x == x_max and y == y_max.
- out_mismatch  out  1  in_addr differed from expected address.
- err_count  out  ERR_W  saturating count of mismatched beats since cfg_load.
- busy  out  1  state is RUN.

## Operation
- States: IDLE and RUN.
  - Reset enters IDLE.
  - cfg_load from either state enters RUN with x = 0, y = 0, acc = 0, err_count = 0. Config registers are latched on the same edge.
  - RUN moves to IDLE on acceptance of the frame_last beat.
  - IDLE never asserts in_ready.
- Expected address is acc + offset, computed with 32-bit wrapping adds.
- Per accepted beat, when in_valid && in_ready:
  - If x != x_max: x++, acc += x_stride.
  - Else if y != y_max: x = 0, y++, acc += y_stride.
  - Else: x = 0, y = 0, acc = 0, and the frame ends.
- Mismatch:
  - out_mismatch = (in_addr != expected).
  - err_count increments when out_mismatch is set and saturates at all-ones.
  - The sequence does not resynchronise: counters advance regardless of mismatch.
- Output register: a one-entry pipeline register.
  - in_ready = busy && (!out_valid || out_ready).
  - out_valid clears when out_ready is high and no new beat is accepted.
  - out_* fields hold stable while out_valid && !out_ready.
- cfg_load while a beat is held (out_valid high):
  - The held beat stays until it is consumed.
  - No beat is accepted on the cfg_load cycle.
- Reset values:
  - in_ready = 0, out_valid = 0.
  - out_x, out_y, out_row_last, out_frame_last and out_mismatch are all 0.
  - err_count = 0, busy = 0, and all config registers are 0.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N. Fields are valid in the cycle following acceptance.
- Throughput is one beat per cycle when out_ready is held high.
- Back-pressure: when out_ready is low with out_valid high, in_ready drops in the same cycle (combinational from out_ready).
- x_max = 0: every beat is row_last, and y advances every beat.
- x_max = 0 and y_max = 0: a single beat forms a frame, and the decoder returns to IDLE.
- Asserting rst mid-frame clears everything immediately, with no partial beat emitted. Deassertion is synchronised externally.

## Structure
- Shared package scan_pkg holds:
  - typedef scan_state_t with values IDLE and RUN.
  - typedef scan_cfg_t, a struct of offset, x_stride, y_stride, x_max and y_max.
  - The constant ADDR_W = 32.
- One sub-module, scan_pos_counter, holds the x/y/acc registers and the advance logic. It can be reused by a future write-side generator.
- The top level holds the FSM, the compare, err_count and the output register.

## Test plan
- Nominal frame:
  - Config: offset = 0x100, x_stride = 4, y_stride = 0x40, x_max = 3, y_max = 1.
  - Feed 0x100, 0x104, 0x108, 0x10C, 0x14C, 0x150, 0x154, 0x158.
  - Required: x = 0..3, 0..3; y = 0 then 1; row_last on beats 4 and 8; frame_last on beat 8; err_count = 0; busy falls after beat 8.
- Back-pressure: same stream with out_ready toggling 1,0,0,1.
  - Required: in_ready tracks out_ready, no beat lost or duplicated, held fields stable.
- Mismatch: corrupt beat 3 to 0x109.
  - Required: out_mismatch on beat 3 only, err_count = 1, beat 4 decodes as x = 3 with no mismatch.
- Degenerate: x_max = 0, y_max = 0, feed 0x100.
  - Required: one beat with row_last = frame_last = 1, then IDLE with in_ready = 0.
- Restart: cfg_load after beat 2 of a frame.
  - Required: next accepted beat decodes as (0,0) and expects offset, err_count = 0.
- Reset mid-frame: rst pulse during beat 5.
  - Required: all outputs 0 immediately, busy = 0 until the next cfg_load.
- Saturation: ERR_W = 2, feed 5 wrong beats.
  - Required: err_count sticks at 3.
